// File: rtl/npu_master_pkg.sv
// npu_master_pkg: shared state encoding and NPU register map for npu_master.
package npu_master_pkg;
   typedef enum logic [2:0] {IDLE, WR_TYPE, WR_INPUT, RD_ADDR, RD_WAIT, RD_OUT} state_t;
   localparam logic [31:0] TYPE_ADDR   = 32'h0;
   localparam logic [31:0] INPUT_ADDR  = 32'h4;
   localparam logic [31:0] OUTPUT_ADDR = 32'h8;
endpackage

// File: rtl/npu_master_if.sv
// npu_master_if: job/input/output streams plus NPU register port bundled for npu_master.
interface npu_master_if #(parameter int DWidth = 32, parameter int LenWidth = 16);
   logic                job_valid, job_ready;
   logic [DWidth-1:0]   job_type;
   logic [LenWidth-1:0] job_len;
   logic                in_valid, in_ready;
   logic [DWidth-1:0]   in_data;
   logic                out_valid, out_ready;
   logic [DWidth-1:0]   out_data;
   logic                npu_wen_type, npu_wen_input;
   logic [DWidth-1:0]   npu_addr, npu_wdata, npu_rdata;
   logic [31:0]         perf_cycles;
   modport master (
      input  job_valid, job_type, job_len, in_valid, in_data, out_ready, npu_rdata,
      output job_ready, in_ready, out_valid, out_data, npu_wen_type, npu_wen_input,
             npu_addr, npu_wdata, perf_cycles
   );
   modport slave (
      output job_valid, job_type, job_len, in_valid, in_data, out_ready, npu_rdata,
      input  job_ready, in_ready, out_valid, out_data, npu_wen_type, npu_wen_input,
             npu_addr, npu_wdata, perf_cycles
   );
endinterface

// File: rtl/npu_master_rdwait.sv
// npu_master_rdwait: counts RdLatency cycles of RD_WAIT and flags the cycle to capture read data.
module npu_master_rdwait #(parameter int RdLatency = 1) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start,
   input  logic busy,
   output logic cap
);
   logic [1:0] cnt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt <= '0;
      else if (start) cnt <= 2'(RdLatency);
      else if (busy && cnt != 2'd0) cnt <= cnt - 2'd1;
   assign cap = busy && cnt == 2'd0;
endmodule

// File: rtl/npu_master.sv
// npu_master: turns stream jobs into NPU type/input writes and a result read, returned as a stream.
// Define NPU_MASTER_PERF_EN to count cycles per job into perf_cycles; otherwise it reads 0.
module npu_master
   import npu_master_pkg::*;
#(
   parameter int DWidth    = 32,
   parameter int LenWidth  = 16,
   parameter int RdLatency = 1
) (
   input logic          clk_i,
   input logic          rst_i,
   npu_master_if.master bus
);
   state_t              state, nxt;
   logic [LenWidth-1:0] len_q;
   logic [DWidth-1:0]   type_q;
   logic                job_hs, in_hs, out_hs, cap;
   assign bus.job_ready = state == IDLE;
   assign bus.in_ready  = state == WR_INPUT;
   assign bus.out_valid = state == RD_OUT;
   assign job_hs = bus.job_valid && bus.job_ready;
   assign in_hs  = bus.in_valid && bus.in_ready;
   assign out_hs = bus.out_valid && bus.out_ready;
   npu_master_rdwait #(.RdLatency(RdLatency)) u_rdwait (
      .clk_i(clk_i), .rst_i(rst_i), .start(state == RD_ADDR), .busy(state == RD_WAIT), .cap(cap)
   );
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (job_hs) nxt = WR_TYPE;
         WR_TYPE:  nxt = len_q != '0 ? WR_INPUT : RD_ADDR;
         WR_INPUT: if (in_hs && len_q == LenWidth'(1)) nxt = RD_ADDR;
         RD_ADDR:  nxt = RD_WAIT;
         RD_WAIT:  if (cap) nxt = RD_OUT;
         RD_OUT:   if (out_hs) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   // NPU-side registers reflect what the current state issues, so each access appears one cycle later
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state             <= IDLE;
         len_q             <= '0;
         type_q            <= '0;
         bus.npu_wen_type  <= 1'b0;
         bus.npu_wen_input <= 1'b0;
         bus.npu_addr      <= '0;
         bus.npu_wdata     <= '0;
         bus.out_data      <= '0;
      end else begin
         state <= nxt;
         if (job_hs) begin
            type_q <= bus.job_type;
            len_q  <= bus.job_len;
         end else if (in_hs) len_q <= len_q - LenWidth'(1);
         bus.npu_wen_type  <= state == WR_TYPE;
         bus.npu_wen_input <= in_hs;
         bus.npu_addr      <= state == WR_TYPE ? DWidth'(TYPE_ADDR) :
                              in_hs ? DWidth'(INPUT_ADDR) :
                              (state == RD_ADDR || state == RD_WAIT) ? DWidth'(OUTPUT_ADDR) : '0;
         bus.npu_wdata     <= state == WR_TYPE ? type_q : in_hs ? bus.in_data : '0;
         if (cap) bus.out_data <= bus.npu_rdata;
      end
`ifdef NPU_MASTER_PERF_EN
   logic [31:0] perf_cnt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         perf_cnt        <= '0;
         bus.perf_cycles <= '0;
      end else begin
         if (job_hs) perf_cnt <= 32'd1;
         else if (state != IDLE && perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
         if (out_hs) bus.perf_cycles <= perf_cnt;
      end
`else
   assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_npu_master.sv
// tb_npu_master: table-driven and randomized jobs against a job-level model of npu_master.
module tb_npu_master;
   localparam int RdLat = 1;
   typedef struct {
      logic [31:0] typ;
      int          len;
      logic [31:0] base;
      logic [31:0] res;
      int          gap;
      int          bp;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   int vectors = 0, miscompares = 0, cyc = 0, proto_bad = 0;
   logic saw_rd = 1'b0;
   logic [31:0] npu_res = '0;
   logic [31:0] din [0:15];
   logic [63:0] wlog [$];
   logic [3:0]  hist = '0;
   vec_t tbl [5];
   npu_master_if #(.DWidth(32), .LenWidth(16)) bus ();
   npu_master #(.DWidth(32), .LenWidth(16), .RdLatency(RdLat)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // NPU model: result only appears RdLat cycles after the read address shows up
   always @(posedge clk) hist <= {hist[2:0], bus.npu_addr == 32'h8};
   assign bus.npu_rdata = (RdLat == 0 ? bus.npu_addr == 32'h8 : hist[(RdLat == 0) ? 0 : RdLat - 1])
                          ? npu_res : 32'hDEADBEEF;
   always @(negedge clk)
      if (!rst) begin
         if (bus.npu_wen_type && bus.npu_wen_input) proto_bad++;
         if (!bus.npu_wen_type && !bus.npu_wen_input && bus.npu_wdata != '0) proto_bad++;
         if (bus.npu_wen_type || bus.npu_wen_input) wlog.push_back({bus.npu_addr, bus.npu_wdata});
         else if (bus.npu_addr == 32'h8) saw_rd = 1'b1;
      end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic do_job(input logic [31:0] typ, input int len, input logic [31:0] res, input int gap, input int bp);
      int t0, tout, n;
      logic hs, stable, busy_ok;
      logic [31:0] d0;
      wlog.delete();
      proto_bad = 0;
      saw_rd = 1'b0;
      npu_res = res;
      chk("job_ready_idle", bus.job_ready, 1);
      bus.job_valid = 1'b1;
      bus.job_type = typ;
      bus.job_len = 16'(len);
      @(posedge clk);
      @(negedge clk);
      bus.job_valid = 1'b0;
      bus.job_type = $urandom;
      bus.job_len = 16'($urandom);
      t0 = cyc;
      for (int i = 0; i < len; i++) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = din[i];
         n = 0;
         do begin
            hs = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
         end while (!hs && n < 50);
         if (!hs) begin
            chk("in_timeout", hs, 1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("out_timeout", bus.out_valid, 1);
      if (gap == 0) chk("latency", cyc - t0, len + RdLat + 3);
      d0 = bus.out_data;
      stable = 1'b1;
      busy_ok = !bus.job_ready;
      repeat (bp) begin
         @(negedge clk);
         if (bus.out_data !== d0 || !bus.out_valid) stable = 1'b0;
         if (bus.job_ready) busy_ok = 1'b0;
      end
      if (bp > 0) chk("bp_stable", stable, 1);
      chk("busy_no_job", busy_ok, 1);
      chk("out_data", bus.out_data, res);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      tout = cyc;
      chk("out_drop", bus.out_valid, 0);
      chk("ready_after", bus.job_ready, 1);
`ifdef NPU_MASTER_PERF_EN
      chk("perf", bus.perf_cycles, tout - t0);
`else
      chk("perf", bus.perf_cycles, 0);
`endif
      chk("wr_count", wlog.size(), len + 1);
      if (wlog.size() > 0) chk("wr_type", wlog[0], {32'h0, typ});
      for (int i = 1; i < wlog.size() && i <= len; i++) chk("wr_input", wlog[i], {32'h4, din[i-1]});
      chk("rd_addr", saw_rd, 1);
      chk("proto", proto_bad, 0);
   endtask
   initial begin
      int n;
      logic hs;
      tbl[0] = '{32'h3, 2, 32'hA, 32'h55, 0, 0};
      tbl[1] = '{32'h1, 0, 32'h0, 32'h77, 0, 0};
      tbl[2] = '{32'h5, 3, 32'h100, 32'h1234, 3, 0};
      tbl[3] = '{32'h7, 1, 32'h20, 32'hABCD, 0, 5};
      tbl[4] = '{32'hFFFFFFFF, 4, 32'hFFFFFFFE, 32'h0, 1, 2};
      bus.job_valid = 1'b0; bus.job_type = '0; bus.job_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_wen", {bus.npu_wen_type, bus.npu_wen_input, bus.out_valid, bus.in_ready}, 0);
      chk("rst_regs", {bus.npu_addr, bus.npu_wdata}, 0);
      chk("rst_out_data", bus.out_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_job_ready", bus.job_ready, 1);
      // reset during the input phase of a 4-word job, right after the second word
      bus.job_valid = 1'b1; bus.job_type = 32'h9; bus.job_len = 16'd4;
      @(posedge clk);
      @(negedge clk);
      bus.job_valid = 1'b0;
      bus.in_valid = 1'b1;
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         bus.in_data = 32'h30 + 32'(n);
         hs = bus.in_ready;
         @(posedge clk);
         @(negedge clk);
         if (hs) n++;
      end
      bus.in_valid = 1'b0;
      chk("pre_rst_strobe", bus.npu_wen_input, 1);
      #2 rst = 1'b1;
      #1 chk("rst_mid_strobes", {bus.npu_wen_type, bus.npu_wen_input}, 0);
      chk("rst_mid_out", bus.out_valid, 0);
      chk("rst_mid_bus", {bus.npu_addr, bus.npu_wdata}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", bus.job_ready, 1);
      hs = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid || bus.npu_wen_type || bus.npu_wen_input) hs = 1'b1;
      end
      chk("rst_no_result", hs, 0);
      foreach (tbl[v]) begin
         for (int i = 0; i < tbl[v].len; i++) din[i] = tbl[v].base + 32'(i);
         do_job(tbl[v].typ, tbl[v].len, tbl[v].res, tbl[v].gap, tbl[v].bp);
      end
      repeat (25) begin
         int len;
         len = $urandom_range(8, 0);
         for (int i = 0; i < len; i++) din[i] = $urandom;
         do_job($urandom, len, $urandom, $urandom_range(2, 0), $urandom_range(3, 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
